// File: rtl/router_pkg.sv
// Shared router types and constants: port naming, arbiter states and the
// default downstream buffer depth used by the input buffers and arbiters.
package router_pkg;

    localparam int unsigned NUM_PORTS       = 5;
    localparam int unsigned DEFAULT_CREDITS = 4;

    typedef enum logic [2:0] {
        PORT_N,
        PORT_E,
        PORT_S,
        PORT_W,
        PORT_L
    } port_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first requester at or above ptr,
// wrapping around, wins. Returns the winner both one-hot and as an index.
module rr_picker
    import router_pkg::*;
#(
    parameter int unsigned N     = NUM_PORTS,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W:0] off;
    logic [IDX_W:0] sum;

    // Rotate so bit 0 of rot is the input at ptr; the lowest set bit of rot
    // is then the winner's offset from ptr.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        off = '0;
        for (int unsigned j = N; j > 0; j--) begin
            if (rot[j-1]) begin
                off = (IDX_W + 1)'(j - 1);
            end
        end
        sum    = off + {1'b0, ptr};
        idx    = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N)) : IDX_W'(sum);
        any    = |req;
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/xbar_port_arbiter.sv
// Per-output wormhole arbiter: locks the output to one input from head to
// tail flit, drives the crossbar select and gates transfers on credits.
module xbar_port_arbiter
    import router_pkg::*;
#(
    parameter int unsigned NUM_IN  = NUM_PORTS,
    parameter int unsigned CREDITS = DEFAULT_CREDITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN-1:0]         req_i,
    input  logic [NUM_IN-1:0]         tail_i,
    input  logic                      credit_ret_i,
    output logic [NUM_IN-1:0]         grant_o,
    output logic [$clog2(NUM_IN)-1:0] sel_o,
    output logic                      valid_o,
    output logic                      busy_o,
    output logic                      credit_err_o
);

    localparam int unsigned SEL_W = $clog2(NUM_IN);
    localparam int unsigned CNT_W = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);

    arb_state_e        state, state_next;
    logic [SEL_W-1:0]  owner, owner_next;
    logic [NUM_IN-1:0] owner_oh, owner_oh_next;
    logic [SEL_W-1:0]  ptr, ptr_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              credit_err, credit_err_next;

    logic [NUM_IN-1:0] pick_onehot;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              fire;

    rr_picker #(
        .N     (NUM_IN),
        .IDX_W (SEL_W)
    ) u_picker (
        .req    (req_i),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        fire = (state == ARB_LOCKED) && req_i[owner] && (cnt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            owner_oh   <= NUM_IN'(1);
            ptr        <= '0;
            cnt        <= CNT_FULL;
            credit_err <= 1'b0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            owner_oh   <= owner_oh_next;
            ptr        <= ptr_next;
            cnt        <= cnt_next;
            credit_err <= credit_err_next;
        end
    end

    // Arbitration ignores credits; a lock may be held with cnt=0 and simply
    // waits for returns.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        owner_oh_next = owner_oh;
        ptr_next      = ptr;
        unique case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_next    = ARB_LOCKED;
                    owner_next    = pick_idx;
                    owner_oh_next = pick_onehot;
                    ptr_next      = (pick_idx == SEL_W'(NUM_IN - 1)) ? '0 : pick_idx + SEL_W'(1);
                end
            end
            ARB_LOCKED: begin
                if (fire && tail_i[owner]) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // A return with the counter already full has nowhere to go: drop it and
    // raise the sticky error.
    always_comb begin
        cnt_next        = cnt;
        credit_err_next = credit_err;
        if (fire && !credit_ret_i) begin
            cnt_next = cnt - CNT_W'(1);
        end else if (!fire && credit_ret_i) begin
            if (cnt == CNT_FULL) begin
                credit_err_next = 1'b1;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        grant_o      = fire ? owner_oh : '0;
        sel_o        = owner;
        valid_o      = fire;
        busy_o       = (state == ARB_LOCKED);
        credit_err_o = credit_err;
    end

endmodule

// File: doc/xbar_port_arbiter.md
# xbar_port_arbiter

Per-output-port wormhole arbiter and credit controller for the NoC router. One instance sits in front of each crossbar output. It chooses which input buffer owns the output, holding the choice from head flit to tail flit, and drives the crossbar select. It also gates every flit transfer on downstream buffer credits returned by the flow-control unit.

## Interface
- NUM_IN, default 5: number of requesting input ports (N, E, S, W, Local).
- CREDITS, default 4: downstream input-buffer depth, in flits.
- clk  in  1  router clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  NUM_IN  input i has a flit at its buffer head routed to this output.
- tail_i  in  NUM_IN  the head flit of input i is a tail flit (single-flit packets set this together with the head flit).
- credit_ret_i  in  1  downstream freed one slot this cycle.
- grant_o  out  NUM_IN  one-hot; the owner's flit transfers this cycle (pops that input buffer).
- sel_o  out  $clog2(NUM_IN)  crossbar select, equal to the current owner index.
- valid_o  out  1  a flit crosses the crossbar this cycle; equal to |grant_o.
- busy_o  out  1  output locked to a packet.
- credit_err_o  out  1  sticky flag: a credit was returned while the counter was full.

## Operation
- States: IDLE and LOCKED.
- IDLE:
  - No grant.
  - If |req_i, pick winner w round-robin, starting the search at ptr and scanning upward with wrap.
  - Next state LOCKED; owner<=w; ptr<=(w+1) mod NUM_IN.
  - Arbitration does not depend on credits; a lock may be taken with cnt=0.
- LOCKED:
  - fire = req_i[owner] && cnt>0.
  - grant_o = fire ? onehot(owner) : 0.
  - If fire && tail_i[owner], next state is IDLE.
  - Requests from non-owners are ignored until release.
  - If req_i[owner] drops mid-packet (input buffer underflow), the state stays LOCKED and no grant is issued.
- sel_o holds owner in both states; it is stale in IDLE and harmless there because valid_o=0.
- busy_o = (state==LOCKED).
- Credit counter cnt, width $clog2(CREDITS+1):
  - Update: cnt_next = cnt − fire + credit_ret_i.
  - Simultaneous fire and credit_ret_i leaves cnt unchanged.
  - A return at cnt==CREDITS with no fire is dropped, and credit_err_o is set.
  - fire is impossible at cnt==0, so no underflow case exists.
- Round-robin fairness: after input i wins, it has lowest priority at the next arbitration.

## Timing
- Reset values:
  - state=IDLE, owner=0, ptr=0, cnt=CREDITS.
  - grant_o=0, valid_o=0, busy_o=0, sel_o=0, credit_err_o=0.
- Arbitration latency: a request seen in IDLE at cycle t gives the first grant at t+1 at the earliest.
- Throughput: one flit per cycle while LOCKED, provided req and credits are present.
- Release bubble:
  - The tail fires at t.
  - IDLE at t+1, where re-arbitration happens.
  - The next packet's first grant is at t+2.
- Credit loop:
  - A credit returned at t is usable for a fire at t+1.
  - grant_o is combinational from registered state and cnt plus the live req_i.
- Reset asserted mid-packet forces IDLE immediately:
  - The lock is abandoned.
  - cnt returns to CREDITS.
  - Cleaning up the downstream partial packet is the responsibility of the router-level reset.

## Structure
- router_pkg holds:
  - NUM_PORTS=5.
  - Port enum PORT_N, PORT_E, PORT_S, PORT_W, PORT_L.
  - Arbiter state enum {ARB_IDLE, ARB_LOCKED}.
  - Default credit depth constant shared with inputbuffer.
- One sub-module, rr_picker: a combinational priority rotate. It takes req and ptr and returns a one-hot winner plus an index. The switch allocator will reuse it.
- Top-level router instantiates one xbar_port_arbiter per output. Their sel_o outputs feed the xbar, and their grant_o outputs are OR-reduced per input to pop the input buffers.

## Test plan
- Reset, then req_i=00001 with tail on the 3rd flit, CREDITS=4:
  - busy_o at cycle 1.
  - grant_o=00001 for cycles 1–3.
  - IDLE at cycle 4.
  - cnt=1 with no returns.
- Contention: req_i=10101 held constant, each packet a single flit:
  - Winners in order 0, 2, 4, 0.
  - Grants every 2 cycles.
  - sel_o follows 0, 2, 4, 0.
- Credit starvation with CREDITS=2 and a 4-flit packet, no returns:
  - Two grants, then grant_o=0 and busy_o=1.
  - A credit_ret_i pulse at cycle t gives one grant at t+1.
- Simultaneous fire and credit_ret_i every cycle:
  - cnt stays constant.
  - 8-flit packet streams at full rate.
- Non-owner preemption attempt: input 3 raises req while input 1 is mid-packet:
  - No grant to 3 until the tail of 1 fires.
  - 3 is granted 2 cycles later.
- Reset mid-packet, with credit_ret_i asserted at cnt=CREDITS beforehand:
  - credit_err_o=1 before reset.
  - After rst_n pulses low, all outputs are 0 and cnt=CREDITS.
  - credit_err_o is cleared.
